// File: rtl/fight_sequencer.sv
// ============================================================================
//  Module   : fight_sequencer
//  Purpose  : Round controller. Arbitrates punches, applies damage, drives the
//             plotter handshake, runs the post-hit cooldown, detects knockout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fight_sequencer #(
  parameter logic [3:0]  HEALTH_INIT = 4'd9,
  parameter logic [3:0]  DAMAGE      = 4'd1,
  parameter logic [15:0] COOLDOWN    = 16'd25000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       player_punch,
  input  logic       player_block,
  input  logic       enemy_punch,
  input  logic       enemy_block,
  input  logic       draw_done,
  output logic [3:0] player_health,
  output logic [3:0] enemy_health,
  output logic       draw_req,
  output logic       draw_who,
  output logic       busy,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RESOLVE  = 3'd1,
    S_DRAW     = 3'd2,
    S_COOLDOWN = 3'd3,
    S_DEAD     = 3'd4
  } state_t;

  localparam logic        c_player    = 1'b0;
  localparam logic        c_enemy     = 1'b1;
  localparam logic [15:0] c_cool_load = COOLDOWN - 16'd1;

  state_t      r_state,         w_state;
  logic        r_attacker,      w_attacker;
  logic        r_last_grant,    w_last_grant;
  logic [3:0]  r_player_health, w_player_health;
  logic [3:0]  r_enemy_health,  w_enemy_health;
  logic        r_draw_req,      w_draw_req;
  logic        r_draw_who,      w_draw_who;
  logic        r_busy,          w_busy;
  logic        r_game_over,     w_game_over;
  logic        r_winner,        w_winner;
  logic [15:0] r_count,         w_count;

  // The defender is always the fighter that did not throw the punch.
  logic       w_target;
  logic       w_target_block;
  logic [3:0] w_target_health;
  logic [3:0] w_damaged;

  assign w_target        = ~r_attacker;
  assign w_target_block  = (w_target == c_enemy) ? enemy_block : player_block;
  assign w_target_health = (w_target == c_enemy) ? r_enemy_health : r_player_health;
  assign w_damaged       = (w_target_health > DAMAGE) ? (w_target_health - DAMAGE) : 4'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_attacker      <= c_player;
      r_last_grant    <= c_enemy;
      r_player_health <= HEALTH_INIT;
      r_enemy_health  <= HEALTH_INIT;
      r_draw_req      <= 1'b0;
      r_draw_who      <= 1'b0;
      r_busy          <= 1'b0;
      r_game_over     <= 1'b0;
      r_winner        <= 1'b0;
      r_count         <= 16'd0;
    end else begin
      r_state         <= w_state;
      r_attacker      <= w_attacker;
      r_last_grant    <= w_last_grant;
      r_player_health <= w_player_health;
      r_enemy_health  <= w_enemy_health;
      r_draw_req      <= w_draw_req;
      r_draw_who      <= w_draw_who;
      r_busy          <= w_busy;
      r_game_over     <= w_game_over;
      r_winner        <= w_winner;
      r_count         <= w_count;
    end
  end

  always_comb begin
    w_state         = r_state;
    w_attacker      = r_attacker;
    w_last_grant    = r_last_grant;
    w_player_health = r_player_health;
    w_enemy_health  = r_enemy_health;
    w_draw_req      = r_draw_req;
    w_draw_who      = r_draw_who;
    w_winner        = r_winner;
    w_count         = r_count;

    case (r_state)
      S_IDLE: begin
        if (player_punch && enemy_punch) begin
          // Tie goes to whoever lost the previous tie; loser's punch is dropped.
          w_attacker   = ~r_last_grant;
          w_last_grant = ~r_last_grant;
          w_state      = S_RESOLVE;
        end else if (player_punch) begin
          w_attacker = c_player;
          w_state    = S_RESOLVE;
        end else if (enemy_punch) begin
          w_attacker = c_enemy;
          w_state    = S_RESOLVE;
        end
      end

      S_RESOLVE: begin
        if (w_target_block) begin
          w_count = c_cool_load;
          w_state = S_COOLDOWN;
        end else begin
          if (w_target == c_enemy) w_enemy_health  = w_damaged;
          else                     w_player_health = w_damaged;
          w_draw_req = 1'b1;
          w_draw_who = w_target;
          w_state    = S_DRAW;
        end
      end

      S_DRAW: begin
        if (draw_done) begin
          w_draw_req = 1'b0;
          if ((r_player_health == 4'd0) || (r_enemy_health == 4'd0)) begin
            w_winner = (r_enemy_health == 4'd0);
            w_state  = S_DEAD;
          end else begin
            w_count = c_cool_load;
            w_state = S_COOLDOWN;
          end
        end
      end

      S_COOLDOWN: begin
        if (r_count == 16'd0) w_state = S_IDLE;
        else                  w_count = r_count - 16'd1;
      end

      S_DEAD: begin
        w_state = S_DEAD;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy      = (w_state != S_IDLE);
    w_game_over = (w_state == S_DEAD);
  end

  assign player_health = r_player_health;
  assign enemy_health  = r_enemy_health;
  assign draw_req      = r_draw_req;
  assign draw_who      = r_draw_who;
  assign busy          = r_busy;
  assign game_over     = r_game_over;
  assign winner        = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_fight_sequencer.sv
// ============================================================================
//  Module   : tb_fight_sequencer
//  Purpose  : Self-checking bench for fight_sequencer (HEALTH_INIT=4, COOLDOWN=3).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fight_sequencer;

  localparam int HI  = 4;
  localparam int DMG = 1;
  localparam int CD  = 3;

  logic       clock;
  logic       reset_n;
  logic       player_punch, player_block, enemy_punch, enemy_block, draw_done;
  logic [3:0] player_health, enemy_health;
  logic       draw_req, draw_who, busy, game_over, winner;

  logic       s_player_punch, s_player_block, s_enemy_punch, s_enemy_block, s_draw_done;
  logic [3:0] s_player_health, s_enemy_health;
  logic       s_draw_req, s_draw_who, s_busy, s_game_over, s_winner;

  int checks = 0;
  int errors = 0;

  fight_sequencer #(.HEALTH_INIT(4'd4), .DAMAGE(4'd1), .COOLDOWN(16'd3)) u_main (
    .clock(clock), .reset_n(reset_n),
    .player_punch(player_punch), .player_block(player_block),
    .enemy_punch(enemy_punch), .enemy_block(enemy_block),
    .draw_done(draw_done),
    .player_health(player_health), .enemy_health(enemy_health),
    .draw_req(draw_req), .draw_who(draw_who), .busy(busy),
    .game_over(game_over), .winner(winner)
  );

  fight_sequencer #(.HEALTH_INIT(4'd4), .DAMAGE(4'd5), .COOLDOWN(16'd3)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .player_punch(s_player_punch), .player_block(s_player_block),
    .enemy_punch(s_enemy_punch), .enemy_block(s_enemy_block),
    .draw_done(s_draw_done),
    .player_health(s_player_health), .enemy_health(s_enemy_health),
    .draw_req(s_draw_req), .draw_who(s_draw_who), .busy(s_busy),
    .game_over(s_game_over), .winner(s_winner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge, well clear of sampling.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // Round model: mode 0 waiting, 1 judging, 2 animating, 3 resting, 4 over.
  int m_mode, m_att, m_last, m_cool;
  int m_h[2];
  int m_req, m_who;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_mode = 0; m_att = 0; m_last = 1; m_cool = 0;
        m_h[0] = HI; m_h[1] = HI; m_req = 0; m_who = 0;
      end else begin
        case (m_mode)
          0: begin
            if (player_punch && enemy_punch) begin
              m_att = 1 - m_last; m_last = m_att; m_mode = 1;
            end else if (player_punch) begin
              m_att = 0; m_mode = 1;
            end else if (enemy_punch) begin
              m_att = 1; m_mode = 1;
            end
          end
          1: begin
            int t, blk;
            t   = 1 - m_att;
            blk = (t == 1) ? int'(enemy_block) : int'(player_block);
            if (blk != 0) begin
              m_cool = CD; m_mode = 3;
            end else begin
              m_h[t] = (m_h[t] - DMG < 0) ? 0 : m_h[t] - DMG;
              m_req = 1; m_who = t; m_mode = 2;
            end
          end
          2: begin
            if (draw_done) begin
              m_req = 0;
              if (m_h[0] == 0 || m_h[1] == 0) m_mode = 4;
              else begin m_cool = CD; m_mode = 3; end
            end
          end
          3: begin
            m_cool--;
            if (m_cool == 0) m_mode = 0;
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset_n) begin
        check("cyc_player_health", player_health, m_h[0]);
        check("cyc_enemy_health", enemy_health, m_h[1]);
        check("cyc_draw_req", draw_req, m_req);
        check("cyc_busy", busy, (m_mode != 0) ? 1 : 0);
        check("cyc_game_over", game_over, (m_mode == 4) ? 1 : 0);
        if (m_req != 0) check("cyc_draw_who", draw_who, m_who);
        if (m_mode == 4) check("cyc_winner", winner, (m_h[1] == 0) ? 1 : 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    player_punch = 0; player_block = 0; enemy_punch = 0; enemy_block = 0; draw_done = 0;
    s_player_punch = 0; s_player_block = 0; s_enemy_punch = 0; s_enemy_block = 0; s_draw_done = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    check("rst_player_health", player_health, 4);
    check("rst_enemy_health", enemy_health, 4);
    check("rst_draw_req", draw_req, 0);
    check("rst_busy", busy, 0);
    check("rst_game_over", game_over, 0);

    // Unblocked player hit
    player_punch = 1; step(); player_punch = 0;
    check("hit_busy_resolve", busy, 1);
    check("hit_health_not_yet", enemy_health, 4);
    step();
    check("hit_enemy_health", enemy_health, 3);
    check("hit_draw_req", draw_req, 1);
    check("hit_draw_who", draw_who, 1);
    repeat (3) step();
    check("hit_req_held", draw_req, 1);
    draw_done = 1; step(); draw_done = 0;
    check("hit_req_dropped", draw_req, 0);
    check("hit_cool_busy0", busy, 1);
    step(); check("hit_cool_busy1", busy, 1);
    step(); check("hit_cool_busy2", busy, 1);
    step(); check("hit_back_idle", busy, 0);

    // Blocked enemy punch
    player_block = 1; enemy_punch = 1; step(); enemy_punch = 0;
    check("blk_busy_resolve", busy, 1);
    step();
    check("blk_no_req", draw_req, 0);
    check("blk_player_health", player_health, 4);
    check("blk_busy_c0", busy, 1);
    step(); check("blk_busy_c1", busy, 1);
    step(); check("blk_busy_c2", busy, 1);
    step(); check("blk_back_idle", busy, 0);
    player_block = 0;

    // Reset pulsed while the plotter is drawing
    player_punch = 1; step(); player_punch = 0; step();
    check("mid_draw_req", draw_req, 1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_draw_req", draw_req, 0);
    check("arst_busy", busy, 0);
    check("arst_enemy_health", enemy_health, 4);
    check("arst_player_health", player_health, 4);
    @(posedge clock); #2 reset_n = 1'b1;

    // First tie: player granted, busy-time punches ignored
    player_punch = 1; enemy_punch = 1; step(); player_punch = 0; enemy_punch = 0;
    step();
    check("tie1_enemy_health", enemy_health, 3);
    check("tie1_draw_who", draw_who, 1);
    player_punch = 1; step(); player_punch = 0; enemy_punch = 1; step(); enemy_punch = 0;
    check("busy_punch_enemy", enemy_health, 3);
    check("busy_punch_player", player_health, 4);
    draw_done = 1; step(); draw_done = 0;
    player_punch = 1; step(); player_punch = 0;
    wait_idle(10);
    check("cool_punch_enemy", enemy_health, 3);

    // Second tie: enemy granted
    player_punch = 1; enemy_punch = 1; step(); player_punch = 0; enemy_punch = 0;
    step();
    check("tie2_player_health", player_health, 3);
    check("tie2_enemy_health", enemy_health, 3);
    check("tie2_draw_who", draw_who, 0);
    draw_done = 1; step(); draw_done = 0;
    wait_idle(10);

    // Knockout
    pulse_reset();
    for (int i = 1; i <= 4; i++) begin
      player_punch = 1; step(); player_punch = 0; step();
      check("ko_enemy_health", enemy_health, 4 - i);
      draw_done = 1; step(); draw_done = 0;
      if (i < 4) wait_idle(10);
    end
    check("ko_game_over", game_over, 1);
    check("ko_winner", winner, 1);
    check("ko_busy", busy, 1);
    player_punch = 1; step(); player_punch = 0; enemy_punch = 1; step(); enemy_punch = 0;
    draw_done = 1; step(); draw_done = 0;
    repeat (3) step();
    check("dead_enemy_health", enemy_health, 0);
    check("dead_player_health", player_health, 4);
    check("dead_game_over", game_over, 1);
    check("dead_winner", winner, 1);

    // Saturating damage on the DAMAGE=5 instance
    pulse_reset();
    s_player_punch = 1; step(); s_player_punch = 0;
    check("sat_busy", s_busy, 1);
    step();
    check("sat_enemy_health", s_enemy_health, 0);
    check("sat_draw_req", s_draw_req, 1);
    check("sat_draw_who", s_draw_who, 1);
    s_draw_done = 1; step(); s_draw_done = 0;
    check("sat_game_over", s_game_over, 1);
    check("sat_winner", s_winner, 1);
    check("sat_player_health", s_player_health, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
